// File: rtl/gray_fb_pkg.sv
// Shared types and constants for the grayscale frame-buffer writer.
// Luma weights are BT.601 scaled by 256; they sum to 256, so luma never overflows.
package gray_fb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_SWAP  = 2'd3
    } state_t;

    localparam int unsigned Y_KR     = 77;
    localparam int unsigned Y_KG     = 150;
    localparam int unsigned Y_KB     = 29;
    localparam int unsigned Y_RND    = 128;
    localparam int unsigned PIPE_LAT = 3;

endpackage

// File: rtl/rgb2luma_pipe.sv
// Two-stage RGB->luma datapath: registers the pixel, then the three weighted products.
// The rounded luma is summed combinationally after the product stage.
module rgb2luma_pipe
    import gray_fb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IDX_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    vld_in,
    input  logic                    last_in,
    input  logic [IDX_WIDTH-1:0]    idx_in,
    input  logic [3*DATA_WIDTH-1:0] rgb_in,
    output logic                    vld_p1,
    output logic                    last_p1,
    output logic [IDX_WIDTH-1:0]    idx_p1,
    output logic [DATA_WIDTH-1:0]   luma_p1
);

    localparam int PW = DATA_WIDTH + 8;
    localparam int SW = DATA_WIDTH + 10;

    logic                  vld_p0;
    logic                  last_p0;
    logic [IDX_WIDTH-1:0]  idx_p0;
    logic [DATA_WIDTH-1:0] r_p0;
    logic [DATA_WIDTH-1:0] g_p0;
    logic [DATA_WIDTH-1:0] b_p0;
    logic [PW-1:0]         prod_r_p1;
    logic [PW-1:0]         prod_g_p1;
    logic [PW-1:0]         prod_b_p1;

    function automatic logic [DATA_WIDTH-1:0] luma_round(
        input logic [PW-1:0] pr,
        input logic [PW-1:0] pg,
        input logic [PW-1:0] pb
    );
        logic [SW-1:0] sum;
        sum = SW'(pr) + SW'(pg) + SW'(pb) + SW'(Y_RND);
        return DATA_WIDTH'(sum >> 8);
    endfunction

    // Stage p0: capture pixel and sidebands
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p0  <= 1'b0;
            last_p0 <= 1'b0;
            idx_p0  <= '0;
            r_p0    <= '0;
            g_p0    <= '0;
            b_p0    <= '0;
        end else begin
            vld_p0  <= vld_in;
            last_p0 <= last_in;
            idx_p0  <= idx_in;
            r_p0    <= rgb_in[3*DATA_WIDTH-1:2*DATA_WIDTH];
            g_p0    <= rgb_in[2*DATA_WIDTH-1:DATA_WIDTH];
            b_p0    <= rgb_in[DATA_WIDTH-1:0];
        end
    end

    // Stage p1: weighted products
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1    <= 1'b0;
            last_p1   <= 1'b0;
            idx_p1    <= '0;
            prod_r_p1 <= '0;
            prod_g_p1 <= '0;
            prod_b_p1 <= '0;
        end else begin
            vld_p1    <= vld_p0;
            last_p1   <= last_p0;
            idx_p1    <= idx_p0;
            prod_r_p1 <= PW'(r_p0) * PW'(Y_KR);
            prod_g_p1 <= PW'(g_p0) * PW'(Y_KG);
            prod_b_p1 <= PW'(b_p0) * PW'(Y_KB);
        end
    end

    assign luma_p1 = luma_round(prod_r_p1, prod_g_p1, prod_b_p1);

endmodule

// File: rtl/gray_fb_writer.sv
// Converts assembled RGB pixels to luma and writes them into a ping-pong frame buffer,
// publishing each complete frame by flipping rd_bank and pulsing frame_ready.
module gray_fb_writer
    import gray_fb_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int TOTAL_PIXELS    = 9600,
    parameter int PIXEL_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [3*DATA_WIDTH-1:0]    rgb_data,
    input  logic                       pixel_done,
    input  logic                       frame_done,
    input  logic                       cam_mode,
    output logic                       fb_we,
    output logic [PIXEL_CNT_WIDTH:0]   fb_addr,
    output logic [DATA_WIDTH-1:0]      fb_wdata,
    output logic                       rd_bank,
    output logic                       frame_ready,
    output logic                       cam_trig,
    output logic                       busy,
    output logic                       err_overrun,
    output logic                       err_short
);

    localparam logic [PIXEL_CNT_WIDTH-1:0] FRAME_LEN = PIXEL_CNT_WIDTH'(TOTAL_PIXELS);

    state_t                     state;
    state_t                     state_nx;
    logic [PIXEL_CNT_WIDTH-1:0] wr_idx;
    logic                       wr_bank;
    logic                       strobe;
    logic                       accept;
    logic                       drop;
    logic                       vld_p1;
    logic                       last_p1;
    logic [PIXEL_CNT_WIDTH-1:0] idx_p1;
    logic [DATA_WIDTH-1:0]      luma_p1;
    logic                       last_p2;

    // A pixel is taken only while filling and only while there is room left in the frame.
    assign strobe = (pixel_done | frame_done) & ~cam_mode;
    assign accept = strobe & ((state == ST_IDLE) | (state == ST_FILL)) & (wr_idx != FRAME_LEN);
    assign drop   = strobe & ~accept;
    assign busy   = (state != ST_IDLE);

    rgb2luma_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_WIDTH  (PIXEL_CNT_WIDTH)
    ) u_pipe (
        .clk     (clk),
        .reset   (reset),
        .vld_in  (accept),
        .last_in (frame_done),
        .idx_in  (wr_idx),
        .rgb_in  (rgb_data),
        .vld_p1  (vld_p1),
        .last_p1 (last_p1),
        .idx_p1  (idx_p1),
        .luma_p1 (luma_p1)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE, ST_FILL: if (accept) state_nx = frame_done ? ST_DRAIN : ST_FILL;
            ST_DRAIN:         if (last_p2) state_nx = ST_SWAP;
            ST_SWAP:          state_nx = ST_IDLE;
            default:          state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            wr_idx      <= '0;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b1;
            frame_ready <= 1'b0;
            cam_trig    <= 1'b0;
            err_overrun <= 1'b0;
            err_short   <= 1'b0;
        end else begin
            state       <= state_nx;
            frame_ready <= 1'b0;
            cam_trig    <= frame_done & cam_mode;
            if (accept)
                wr_idx <= wr_idx + PIXEL_CNT_WIDTH'(1);
            if (drop)
                err_overrun <= 1'b1;
            // The final write has retired here, so wr_idx equals the number of pixels written.
            if (state == ST_SWAP) begin
                wr_idx <= '0;
                if (wr_idx == FRAME_LEN) begin
                    rd_bank     <= wr_bank;
                    wr_bank     <= ~wr_bank;
                    frame_ready <= 1'b1;
                end else begin
                    err_short <= 1'b1;
                end
            end
        end
    end

    // Stage p2: BRAM write port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fb_we    <= 1'b0;
            last_p2  <= 1'b0;
            fb_addr  <= '0;
            fb_wdata <= '0;
        end else begin
            fb_we    <= vld_p1;
            last_p2  <= vld_p1 & last_p1;
            fb_addr  <= {wr_bank, idx_p1};
            fb_wdata <= luma_p1;
        end
    end

endmodule
